// File: rtl/mseq_pkg.sv
// Shared types and constants for the micro_sequencer block.
// Holds microword/control-word layout, COND codes, FSM states and defaults.
package mseq_pkg;

  localparam int UPC_W_DEF = 4;
  localparam int CW_W_DEF  = 16;
  localparam int UW_W_DEF  = CW_W_DEF + UPC_W_DEF + 4;

  // Microword layout at the default widths
  localparam int UW_CW_LSB   = 0;
  localparam int UW_TGT_LSB  = 16;
  localparam int UW_COND_LSB = 20;
  localparam int UW_LDDI_BIT = 23;

  // Datapath control-word layout
  localparam int CW_DA_LSB = 13;
  localparam int CW_AA_LSB = 10;
  localparam int CW_BA_LSB = 7;
  localparam int CW_MB_BIT = 6;
  localparam int CW_FS_LSB = 2;
  localparam int CW_MD_BIT = 1;
  localparam int CW_RW_BIT = 0;

  // Issue count at which the next RUN issue would reach 255
  localparam logic [7:0] WDOG_LIMIT = 8'd254;

  typedef enum logic [2:0] {
    COND_NEXT = 3'd0,
    COND_JMP  = 3'd1,
    COND_Z    = 3'd2,
    COND_N    = 3'd3,
    COND_C    = 3'd4,
    COND_V    = 3'd5,
    COND_T    = 3'd6,
    COND_HALT = 3'd7
  } cond_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
    logic t;
  } flags_t;

  function automatic logic cond_true(
    input cond_e  cond,
    input flags_t f
  );
    logic r;
    r = 1'b0;
    unique case (cond)
      COND_NEXT: r = 1'b0;
      COND_JMP:  r = 1'b1;
      COND_Z:    r = f.z;
      COND_N:    r = f.n;
      COND_C:    r = f.c;
      COND_V:    r = f.v;
      COND_T:    r = f.t;
      COND_HALT: r = 1'b0;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mseq_ucode_ram.sv
// Writable microcode store: synchronous write, asynchronous read, no reset.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module mseq_ucode_ram #(
  parameter int AW = 4,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/micro_sequencer.sv
// Microprogrammed controller: issues one control word per clock from a
// writable store, branches on V/C/N/Z/Tbit, latches Data_in into DI.
// Ports: Clk, Rst_n, Start/Busy/Done, Prog_* load port, Data_in/DI,
// flags, Y control word, Upc debug. Macro MSEQ_WDOG_EN adds a
// watchdog abort and the sticky Wdog_err output.
module micro_sequencer
  import mseq_pkg::*;
#(
  parameter int UPC_W = UPC_W_DEF,
  parameter int CW_W  = CW_W_DEF,
  parameter int UW_W  = CW_W + UPC_W + 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  input  logic             Prog_we,
  input  logic [UPC_W-1:0] Prog_addr,
  input  logic [UW_W-1:0]  Prog_data,
  input  logic [7:0]       Data_in,
  output logic [7:0]       DI,
  input  logic             V,
  input  logic             C,
  input  logic             N,
  input  logic             Z,
  input  logic             Tbit,
  output logic [CW_W-1:0]  Y,
  output logic [UPC_W-1:0] Upc
`ifdef MSEQ_WDOG_EN
  ,
  output logic             Wdog_err
`endif
);

  localparam int TGT_LSB  = CW_W;
  localparam int COND_LSB = CW_W + UPC_W;
  localparam int LDDI_BIT = UW_W - 1;

  state_e           state_q, state_d;
  logic [CW_W-1:0]  y_q, y_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  logic [7:0]       di_q, di_d;
  logic             done_q, done_d;
  logic             halt_q, halt_d;

  logic [UPC_W-1:0] rd_addr;
  logic [UW_W-1:0]  rd_data;
  logic             ram_we;

  logic [CW_W-1:0]  uw_cw;
  logic [UPC_W-1:0] uw_tgt;
  cond_e            uw_cond;
  logic             uw_ld;
  logic [UPC_W-1:0] upc_nxt;
  flags_t           flags;

  logic             issue;
  logic             launch;
  logic             wdog_trip;

  // Launch always fetches word 0; while idle Upc sits at 0 anyway
  assign rd_addr = (state_q == S_IDLE) ? '0 : upc_q;

  mseq_ucode_ram #(
    .AW (UPC_W),
    .DW (UW_W)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .waddr (Prog_addr),
    .wdata (Prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign uw_cw   = rd_data[CW_W-1:0];
  assign uw_tgt  = rd_data[TGT_LSB +: UPC_W];
  assign uw_cond = cond_e'(rd_data[COND_LSB +: 3]);
  assign uw_ld   = rd_data[LDDI_BIT];

  assign flags = '{v: V, c: C, n: N, z: Z, t: Tbit};

  assign upc_nxt = cond_true(uw_cond, flags)
                 ? uw_tgt
                 : rd_addr + UPC_W'(1);

`ifdef MSEQ_WDOG_EN
  logic [7:0] wdog_q, wdog_d;
  logic       err_q, err_d;

  assign wdog_trip = (wdog_q == WDOG_LIMIT);

  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q;
    if (launch) begin
      wdog_d = '0;
      err_d  = 1'b0;
    end else if (issue) begin
      wdog_d = wdog_q + 8'd1;
    end else if (state_q == S_RUN && !halt_q && wdog_trip) begin
      err_d  = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign Wdog_err = err_q;
`else
  assign wdog_trip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    upc_d   = upc_q;
    di_d    = di_q;
    done_d  = 1'b0;
    halt_d  = halt_q;
    issue   = 1'b0;
    launch  = 1'b0;
    ram_we  = 1'b0;

    unique case (1'b1)
      (state_q == S_IDLE): begin
        y_d   = '0;
        upc_d = '0;
        if (Start) begin
          launch  = 1'b1;
          state_d = S_RUN;
        end else begin
          ram_we  = Prog_we;
        end
      end
      (state_q == S_RUN): begin
        // halt_q: the halt word went out last edge
        if (halt_q) begin
          state_d = S_IDLE;
          y_d     = '0;
          upc_d   = '0;
          halt_d  = 1'b0;
          done_d  = 1'b1;
        end else if (wdog_trip) begin
          state_d = S_IDLE;
          y_d     = '0;
          upc_d   = '0;
        end else begin
          issue   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue || launch) begin
      y_d    = uw_cw;
      upc_d  = upc_nxt;
      halt_d = (uw_cond == COND_HALT);
      if (uw_ld) begin
        di_d = Data_in;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      upc_q   <= '0;
      di_q    <= '0;
      done_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      upc_q   <= upc_d;
      di_q    <= di_d;
      done_q  <= done_d;
      halt_q  <= halt_d;
    end
  end

  assign Busy = (state_q == S_RUN);
  assign Done = done_q;
  assign DI   = di_q;
  assign Y    = y_q;
  assign Upc  = upc_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: a microprogram interpreter model
// pushes expected per-edge outputs; a negedge monitor pops and compares.
module tb_micro_sequencer;

  localparam bit WDOG =
`ifdef MSEQ_WDOG_EN
    1'b1;
`else
    1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        Prog_we = 1'b0;
  logic [3:0]  Prog_addr = '0;
  logic [23:0] Prog_data = '0;
  logic [7:0]  Data_in = '0;
  logic        V = 1'b0, C = 1'b0, N = 1'b0, Z = 1'b0, Tbit = 1'b0;
  logic        Busy, Done;
  logic [7:0]  DI;
  logic [15:0] Y;
  logic [3:0]  Upc;
  logic        Wdog_err;

  micro_sequencer dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Busy      (Busy),
    .Done      (Done),
    .Prog_we   (Prog_we),
    .Prog_addr (Prog_addr),
    .Prog_data (Prog_data),
    .Data_in   (Data_in),
    .DI        (DI),
    .V         (V),
    .C         (C),
    .N         (N),
    .Z         (Z),
    .Tbit      (Tbit),
    .Y         (Y),
    .Upc       (Upc)
`ifdef MSEQ_WDOG_EN
    ,
    .Wdog_err  (Wdog_err)
`endif
  );

`ifndef MSEQ_WDOG_EN
  assign Wdog_err = 1'b0;
`endif

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] y;
    logic [3:0]  upc;
    logic [7:0]  di;
    logic        busy;
    logic        done;
    logic        err;
  } rec_t;

  rec_t q[$];
  rec_t mr;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: the program store and the interpreter's state
  logic [23:0] mem_m [16];
  bit          run_m, fin_m, err_m;
  logic [3:0]  pc_m;
  logic [7:0]  di_m;
  int          wd_m;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit cond_ok(logic [2:0] c);
    case (c)
      3'd1:    return 1'b1;
      3'd2:    return Z;
      3'd3:    return N;
      3'd4:    return C;
      3'd5:    return V;
      3'd6:    return Tbit;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_issue(input logic [3:0] a, output logic [15:0] y);
    logic [23:0] w;
    w = mem_m[a];
    y = w[15:0];
    if (w[23]) di_m = Data_in;
    if (w[22:20] == 3'd7) fin_m = 1'b1;
    pc_m = cond_ok(w[22:20]) ? w[19:16] : a + 4'd1;
  endtask

  task automatic m_edge(output rec_t r);
    r.y    = '0;
    r.done = 1'b0;
    if (fin_m) begin
      run_m = 1'b0;
      fin_m = 1'b0;
      pc_m  = '0;
      r.done = 1'b1;
    end else if (run_m) begin
      if (WDOG && wd_m == 254) begin
        run_m = 1'b0;
        pc_m  = '0;
        err_m = 1'b1;
      end else begin
        wd_m++;
        m_issue(pc_m, r.y);
      end
    end else if (Start) begin
      wd_m  = 0;
      err_m = 1'b0;
      run_m = 1'b1;
      m_issue(4'd0, r.y);
    end else if (Prog_we) begin
      mem_m[Prog_addr] = Prog_data;
    end
    r.upc  = pc_m;
    r.di   = di_m;
    r.busy = run_m;
    r.err  = err_m;
  endtask

  task automatic m_reset();
    run_m = 1'b0;
    fin_m = 1'b0;
    err_m = 1'b0;
    pc_m  = '0;
    di_m  = '0;
    wd_m  = 0;
  endtask

  task automatic step(input bit st, input bit we, input logic [3:0] a,
                      input logic [23:0] d, input logic [7:0] din,
                      input logic [3:0] fl, input bit tb);
    rec_t r;
    Start = st;
    Prog_we = we;
    Prog_addr = a;
    Prog_data = d;
    Data_in = din;
    {V, C, N, Z} = fl;
    Tbit = tb;
    m_edge(r);
    @(posedge Clk);
    q.push_back(r);
    #2;
  endtask

  task automatic prog(input logic [3:0] a, input logic [23:0] d);
    step(1'b0, 1'b1, a, d, 8'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic launch(input logic [7:0] din, input logic [3:0] fl,
                        input bit tb);
    step(1'b1, 1'b0, 4'd0, 24'd0, din, fl, tb);
  endtask

  task automatic run_to_idle(input int max, input logic [3:0] fl,
                             input bit tb);
    int n;
    n = 0;
    while (Busy && n < max) begin
      step(1'b0, 1'b0, 4'd0, 24'd0, 8'($urandom), fl, tb);
      n++;
    end
    chk("run_timeout", {31'd0, Busy}, 32'd0);
    step(1'b0, 1'b0, 4'd0, 24'd0, 8'($urandom), fl, tb);
  endtask

  task automatic reset_async();
    Start = 1'b0;
    Prog_we = 1'b0;
    #5;
    Rst_n = 1'b0;
    #1;
    chk("rst_y", {16'd0, Y}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_upc", {28'd0, Upc}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_di", {24'd0, DI}, 32'd0);
    m_reset();
    @(posedge Clk);
    #2;
    Rst_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      if (!Rst_n) continue;
      if (q.size() > 0) begin
        mr = q.pop_front();
        chk("y", {16'd0, Y}, {16'd0, mr.y});
        chk("upc", {28'd0, Upc}, {28'd0, mr.upc});
        chk("di", {24'd0, DI}, {24'd0, mr.di});
        chk("busy", {31'd0, Busy}, {31'd0, mr.busy});
        chk("done", {31'd0, Done}, {31'd0, mr.done});
        if (WDOG) chk("wdog_err", {31'd0, Wdog_err}, {31'd0, mr.err});
      end else if (Busy || Done) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: busy %0b done %0b y %0h",
                 Busy, Done, Y);
      end
    end
  end

  initial begin
    int n;
    m_reset();
    repeat (2) @(posedge Clk);
    #2;
    chk("init_y", {16'd0, Y}, 32'd0);
    chk("init_busy", {31'd0, Busy}, 32'd0);
    chk("init_upc", {28'd0, Upc}, 32'd0);
    chk("init_di", {24'd0, DI}, 32'd0);
    chk("init_done", {31'd0, Done}, 32'd0);
    Rst_n = 1'b1;
    for (int i = 0; i < 16; i++) prog(4'(i), 24'h0);

    // Linear program with operand loads
    prog(4'd0, 24'h802003);
    prog(4'd1, 24'h804003);
    prog(4'd2, 24'h708515);
    launch(8'h05, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 24'd0, 8'h0A, 4'h0, 1'b0);
    run_to_idle(10, 4'h0, 1'b0);
    chk("linear_di", {24'd0, DI}, 32'h0A);

    // Tbit branch, taken then not taken
    prog(4'd0, 24'h000011);
    prog(4'd1, 24'h650022);
    prog(4'd2, 24'h000033);
    prog(4'd3, 24'h000044);
    prog(4'd4, 24'h000066);
    prog(4'd5, 24'h700055);
    launch(8'h11, 4'h0, 1'b1);
    run_to_idle(10, 4'h0, 1'b1);
    launch(8'h22, 4'h0, 1'b0);
    run_to_idle(10, 4'h0, 1'b0);

    // Z branch sampled on the edge issuing word 2
    prog(4'd1, 24'h000014);
    prog(4'd2, 24'h270000);
    prog(4'd3, 24'h700033);
    prog(4'd7, 24'h7000AA);
    launch(8'h33, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 24'd0, 8'h0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 24'd0, 8'h0, 4'h1, 1'b0);
    chk("z_branch_upc", {28'd0, Upc}, 32'd7);
    run_to_idle(10, 4'h0, 1'b0);

    // Wrap 15 -> 0, with Start/Prog_we ignored while busy
    prog(4'd0, 24'h6E0101);
    prog(4'd1, 24'h000111);
    prog(4'd2, 24'h700222);
    prog(4'd14, 24'h000E0E);
    prog(4'd15, 24'h000F0F);
    launch(8'h44, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 24'd0, 8'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'd2, 24'h000000, 8'h0, 4'h0, 1'b0);
    run_to_idle(10, 4'h0, 1'b0);
    launch(8'h55, 4'h0, 1'b1);
    run_to_idle(10, 4'h0, 1'b0);

    // Reset mid-run of a 4-word loop, twice
    prog(4'd0, 24'h000A01);
    prog(4'd1, 24'h000A02);
    prog(4'd2, 24'h000A03);
    prog(4'd3, 24'h100A04);
    repeat (2) begin
      launch(8'h66, 4'h0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 24'd0, 8'h0, 4'h0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 24'd0, 8'h0, 4'h0, 1'b0);
      reset_async();
    end

    if (WDOG) begin
      prog(4'd0, 24'h100001);
      launch(8'h77, 4'h0, 1'b0);
      n = 1;
      while (Busy && n < 400) begin
        step(1'b0, 1'b0, 4'd0, 24'd0, 8'h0, 4'h0, 1'b0);
        if (Busy) n++;
      end
      chk("wdog_issues", 32'(n), 32'd255);
      chk("wdog_err_set", {31'd0, Wdog_err}, 32'd1);
      step(1'b0, 1'b0, 4'd0, 24'd0, 8'h0, 4'h0, 1'b0);
      launch(8'h78, 4'h0, 1'b0);
      chk("wdog_err_clr", {31'd0, Wdog_err}, 32'd0);
      reset_async();
    end

    // Randomised programs and noisy control inputs
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 16; i++) prog(4'(i), 24'($urandom));
      launch(8'($urandom), 4'($urandom), 1'($urandom));
      for (int k = 0; k < 40; k++) begin
        step(($urandom % 4) == 0, ($urandom % 4) == 0, 4'($urandom),
             24'($urandom), 8'($urandom), 4'($urandom), 1'($urandom));
      end
      reset_async();
    end

    #10;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
